// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants, FSM encoding and buffer entry type for fetch.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous {pc,instr} buffer with flush and occupancy count.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  fetch_entry_t                 i_data,
    input  logic                         i_pop,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH - 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            w_do_pop;
    logic            w_full;

    assign w_do_pop = i_pop && (r_count != '0);
    assign w_full   = (r_count == c_cw'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I fetch front end: credit-limited imem requests, redirect
//            with in-flight response dropping, buffered delivery to decode.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_condition_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam int c_cw = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cw:0] c_credit = (c_cw + 1)'(FIFO_DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [31:0]     r_pc;
    logic [31:0]     w_pc_next;
    logic [31:0]     r_rsp_pc;
    logic [31:0]     w_rsp_pc_next;
    logic [c_cw-1:0] r_outstanding;
    logic [c_cw-1:0] w_outstanding_next;
    logic [c_cw-1:0] r_drop_cnt;
    logic [c_cw-1:0] w_drop_cnt_next;
    logic [c_cw-1:0] w_fifo_count;
    logic [c_cw:0]   w_credit_used;
    logic [31:0]     w_target;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_empty;
    logic            w_unused_tgt_lsbs;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    assign w_target          = {branch_target_i[31:2], 2'b00};
    assign w_unused_tgt_lsbs = &{1'b0, branch_target_i[1:0]};

    // Request valid depends only on registered state, never on the redirect input.
    assign w_credit_used    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid_o = (r_state != ST_BOOT) && (w_credit_used < c_credit);
    assign imem_req_addr_o  = r_pc;

    assign w_req_fire  = imem_req_valid_o && imem_req_ready_i;
    assign w_push      = imem_rsp_valid_i && !branch_condition_i && (r_drop_cnt == '0);
    assign w_pop       = instr_valid_o && instr_ready_i;
    assign w_push_data = {r_rsp_pc, imem_rsp_data_i};

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_req_fire && !imem_rsp_valid_i) begin
            w_outstanding_next = r_outstanding + 1'b1;
        end else if (!w_req_fire && imem_rsp_valid_i) begin
            w_outstanding_next = r_outstanding - 1'b1;
        end

        // A redirect reloads the drop count from the post-update outstanding count.
        w_drop_cnt_next = r_drop_cnt;
        if (branch_condition_i) begin
            w_drop_cnt_next = w_outstanding_next;
        end else if (imem_rsp_valid_i && (r_drop_cnt != '0)) begin
            w_drop_cnt_next = r_drop_cnt - 1'b1;
        end

        w_pc_next = r_pc;
        if (branch_condition_i) begin
            w_pc_next = w_target;
        end else if (w_req_fire) begin
            w_pc_next = r_pc + 32'd4;
        end

        w_rsp_pc_next = r_rsp_pc;
        if (branch_condition_i) begin
            w_rsp_pc_next = w_target;
        end else if (w_push) begin
            w_rsp_pc_next = r_rsp_pc + 32'd4;
        end

        w_state_next = r_state;
        case (r_state)
            ST_BOOT:          w_state_next = ST_RUN;
            ST_RUN, ST_DRAIN: w_state_next = (w_drop_cnt_next != '0) ? ST_DRAIN : ST_RUN;
            default:          w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_rsp_pc      <= w_rsp_pc_next;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_flush (branch_condition_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with an in-order memory model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch;
    logic [31:0] tgt;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        w_rsp_valid;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          cyc    = 0;
    int          since_rst;
    int          lat;
    int          n_req;
    int          first_valid;
    bit          nop_data;
    bit          last_pop;
    bit          w_pend;
    bit          found;
    logic [31:0] last_pop_pc;
    logic [31:0] exp_fetch_pc;
    logic [31:0] w_exp_addr;
    logic [31:0] w_exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .branch_condition_i (branch),
        .branch_target_i    (tgt),
        .imem_req_valid_o   (req_valid),
        .imem_req_ready_i   (req_ready),
        .imem_req_addr_o    (req_addr),
        .imem_rsp_valid_i   (rsp_valid),
        .imem_rsp_data_i    (rsp_data),
        .instr_valid_o      (instr_valid),
        .instr_ready_i      (instr_ready),
        .instr_o            (instr),
        .instr_pc_o         (instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk_i              (clk),
        .rst_i              (rst),
        .branch_condition_i (1'b0),
        .branch_target_i    (32'h0),
        .imem_req_valid_o   (w_req_valid),
        .imem_req_ready_i   (1'b1),
        .imem_req_addr_o    (w_req_addr),
        .imem_rsp_valid_i   (w_rsp_valid),
        .imem_rsp_data_i    (NOP),
        .instr_valid_o      (w_instr_valid),
        .instr_ready_i      (1'b1),
        .instr_o            (w_instr),
        .instr_pc_o         (w_instr_pc)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return nop_data ? NOP : (NOP ^ {a[24:0], 7'b0});
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        branch      = 1'b0;
        tgt         = 32'h0;
        req_ready   = 1'b1;
        rsp_valid   = 1'b0;
        rsp_data    = 32'h0;
        instr_ready = 1'b1;
        w_rsp_valid = 1'b0;
        mem_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        since_rst    = 0;
        n_req        = 0;
        first_valid  = -1;
        w_pend       = 1'b0;
        exp_fetch_pc = 32'h0;
        w_exp_addr   = 32'hFFFF_FFFC;
        w_exp_pc     = 32'hFFFF_FFFC;
    endtask

    // One clock: compare at the falling edge, update the models, then drive the next cycle.
    task automatic tick();
        bit    exp_rv;
        bit    fire;
        mreq_t m;
        exp_t  e;
        @(negedge clk);
        exp_rv = (since_rst != 0) && ((mem_q.size() + exp_q.size()) < 2);
        check("req_valid", 32'(req_valid), 32'(exp_rv));
        check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (instr_valid && exp_q.size() != 0) begin
            check("head_pc", instr_pc, exp_q[0].pc);
            check("head_instr", instr, exp_q[0].instr);
        end
        if (instr_valid && first_valid < 0) first_valid = since_rst;
        last_pop = instr_valid && instr_ready;
        if (last_pop && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_pop_pc = e.pc;
        end
        if (rsp_valid && mem_q.size() != 0) begin
            m = mem_q.pop_front();
            if (!m.stale && !branch) exp_q.push_back('{m.addr, rsp_data});
        end
        fire = req_valid && req_ready;
        if (fire) begin
            check("req_addr", req_addr, exp_fetch_pc);
            mem_q.push_back('{req_addr, cyc + lat, 1'b0});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            n_req++;
        end
        if (branch) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_q.delete();
            exp_fetch_pc = {tgt[31:2], 2'b00};
        end
        if (w_instr_valid) begin
            check("wrap_pc", w_instr_pc, w_exp_pc);
            check("wrap_instr", w_instr, NOP);
            w_exp_pc = w_exp_pc + 32'd4;
        end
        w_pend = w_req_valid;
        if (w_req_valid) begin
            check("wrap_addr", w_req_addr, w_exp_addr);
            w_exp_addr = w_exp_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        since_rst++;
        branch = 1'b0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = word_of(mem_q[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'hDEAD_BEEF;
        end
        w_rsp_valid = w_pend;
    endtask

    task automatic wait_first_pop(input string tag, input logic [31:0] exp_pc);
        last_pop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_pop) break;
        end
        check({tag, "_pop_seen"}, 32'(last_pop), 32'd1);
        check({tag, "_pc"}, last_pop_pc, exp_pc);
    endtask

    initial begin
        nop_data = 1'b1;
        lat      = 1;

        do_reset();
        repeat (10) tick();
        check("first_valid_lat", 32'(first_valid), 32'd3);

        // Decode stalled from reset: only credit-limited requests go out.
        do_reset();
        instr_ready = 1'b0;
        repeat (12) tick();
        check("stall_req_count", 32'(n_req), 32'd2);
        check("stall_req_valid", 32'(req_valid), 32'd0);
        check("stall_head_pc", instr_pc, 32'h0);

        nop_data    = 1'b0;
        lat         = 3;
        instr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mem_q.size() >= 2) break;
            tick();
        end
        check("two_outstanding", 32'(mem_q.size()), 32'd2);
        tgt    = 32'h0000_0100;
        branch = 1'b1;
        tick();
        wait_first_pop("redir_100", 32'h0000_0100);

        tgt    = 32'h0000_0203;
        branch = 1'b1;
        tick();
        wait_first_pop("redir_203", 32'h0000_0200);

        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid && instr_valid && exp_q.size() != 0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rsp_pop_cycle_found", 32'(found), 32'd1);
        tgt    = 32'h0000_0400;
        branch = 1'b1;
        tick();
        check("redir_pop_done", 32'(last_pop), 32'd1);
        check("flush_empty", 32'(instr_valid), 32'd0);
        wait_first_pop("redir_400", 32'h0000_0400);

        repeat (8) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the RV32I core and the consumer of the execute-stage branch decision (branch_condition / target).
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PCs in a small FIFO and hands them to decode over valid/ready.
- On a taken branch/jump it redirects the PC, flushes buffered instructions, and discards responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, number of instruction buffer entries; also the total request credit.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset; one clock; synchronous, active-high
- branch_condition_i  input  1  execute stage: taken branch/JAL/JALR this cycle
- branch_target_i  input  32  redirect address; bits [1:0] are ignored (treated as 00)
- imem_req_valid_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts the request
- imem_req_addr_o  output  32  fetch address
- imem_rsp_valid_i  input  1  response word valid; in-order, no backpressure
- imem_rsp_data_i  input  32  instruction word
- instr_valid_o  output  1  instruction available to decode
- instr_ready_i  input  1  decode accepts
- instr_o  output  32  instruction word (FIFO head)
- instr_pc_o  output  32  PC of instr_o

Behaviour:
- Reset values, while rst_i=1 and the cycle after:
  - imem_req_valid_o=0, imem_req_addr_o=RESET_PC
  - instr_valid_o=0, instr_o=0, instr_pc_o=0
  - outstanding=0, drop_cnt=0, FIFO empty, rsp_pc=RESET_PC, state=ST_BOOT
- FSM:
  - ST_BOOT: one cycle with no requests, then ST_RUN.
  - ST_RUN: normal fetch.
  - ST_DRAIN: entered on a redirect when drop_cnt>0 after the update; returns to ST_RUN when drop_cnt reaches 0.
  - Requests may issue in both ST_RUN and ST_DRAIN.
- Credit rule: imem_req_valid_o=1 iff state≠ST_BOOT and outstanding + fifo_count < FIFO_DEPTH.
  - imem_req_valid_o is registered logic only; there is no combinational path from branch_condition_i.
- Request accept (valid & ready): pc ← pc+4 (wraps 32'hFFFF_FFFC → 0), outstanding+1.
- Response handling:
  - Every response decrements outstanding.
  - If drop_cnt>0, the word is discarded and drop_cnt−1.
  - Otherwise push {rsp_pc, data} into the FIFO and rsp_pc ← rsp_pc+4.
- Latency:
  - Request accepted in cycle N, response no earlier than N+1.
  - instr_valid_o rises the cycle after the push.
  - Minimum request-to-decode latency is 2 cycles.
- Decode handshake: instr_valid_o & instr_ready_i pops the FIFO head. instr_o and instr_pc_o are stable while valid and not ready.
- Redirect (branch_condition_i=1 in cycle R) has highest priority. In cycle R+1:
  - pc = rsp_pc = {target[31:2],2'b00}
  - FIFO empty; instr_valid_o=0
  - drop_cnt = outstanding at end of R, i.e. including a request accepted in R and excluding a response consumed in R
  - A response arriving in R is discarded, never pushed.
  - A decode pop in R completes normally before the flush.
- Back-to-back redirects: the later redirect wins. drop_cnt is recomputed from the current outstanding count; it is not summed with the earlier value.
- Full FIFO: credit rule guarantees no overflow. A push on a full FIFO is a design error, flagged by a simulation-only assertion.
- Reset mid-operation: all state returns to reset values. Responses arriving after reset must not exist by system contract; the bench guarantees this.

Decomposition:
- Package fetch_pkg holds:
  - RESET_PC default
  - NOP constant 32'h0000_0013
  - state encodings ST_BOOT/ST_RUN/ST_DRAIN
  - branch opcode constants 7'b1100011, 7'b1101111, 7'b1100111, shared with the branch logic
- Sub-module fetch_fifo: synchronous FIFO, width 64 {pc,instr}, depth FIFO_DEPTH, with flush input and count output.

Test Plan:
- Reset release, imem_req_ready_i=1, responses with 1-cycle latency returning 0x00000013 → requests to 0x0, 0x4, 0x8…; instr_pc_o sequence 0x0, 0x4, 0x8 with instr_o=0x13; first instr_valid_o 3 cycles after rst_i falls.
- instr_ready_i=0 for 10 cycles → exactly 2 requests issued, FIFO holds PCs 0x0, 0x4, imem_req_valid_o=0; outputs held stable; releasing ready resumes fetch at 0x8.
- Redirect with 2 requests outstanding (0x8, 0xC), target 0x100 → both responses discarded, next request 0x100, first delivered instr_pc_o=0x100, drop_cnt returns to 0.
- Target 0x203 → request address 0x200 and instr_pc_o=0x200.
- Redirect in the same cycle as a response and a decode pop → popped instruction delivered, response discarded, FIFO empty next cycle.
- RESET_PC=32'hFFFF_FFFC → second request address 0x0000_0000, PCs wrap without error.
